// File: rtl/sprite_render.sv
// Sprite position/movement, raster hit test, ROM address sequencing and
// one-pixel-latency colour output for the VGA colour mux.
module sprite_render #(
    parameter int          SPR_W   = 34,
    parameter int          SPR_H   = 36,
    parameter int          ADDR_W  = 11,
    parameter int          START_X = 303,
    parameter int          START_Y = 222,
    parameter int          STEP    = 2,
    parameter logic [7:0]  TRANSP  = 8'h00
) (
    input  logic              i_clk2,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic              i_frame_stb,
    input  logic              i_active,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic              i_left,
    input  logic              i_right,
    input  logic              i_up,
    input  logic              i_down,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic [7:0]        o_pixel,
    output logic              o_opaque,
    output logic [9:0]        o_pos_x,
    output logic [9:0]        o_pos_y
);
    localparam logic [10:0]       XMAX = 11'(640 - SPR_W);
    localparam logic [10:0]       YMAX = 11'(480 - SPR_H);
    localparam logic [10:0]       STP  = 11'(STEP);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SPR_W * SPR_H - 1);

    logic [9:0]        r_pos_x, r_pos_y;
    logic [ADDR_W-1:0] r_cnt, r_rom_addr;
    logic              r_hit_d, r_opaque;
    logic [7:0]        r_pixel;

    logic [10:0] w_x, w_y, w_px, w_py, w_nx, w_ny;
    logic        w_hit;

    // 11-bit compares so pos+size never overflows the raster width
    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_px = {1'b0, r_pos_x};
    assign w_py = {1'b0, r_pos_y};
    assign w_hit = i_active
                 && (w_x >= w_px) && (w_x <= w_px + 11'(SPR_W - 1))
                 && (w_y >= w_py) && (w_y <= w_py + 11'(SPR_H - 1));

    always_comb begin
        w_nx = w_px;
        if (i_left && !i_right)
            w_nx = (w_px < STP) ? 11'd0 : w_px - STP;
        else if (i_right && !i_left)
            w_nx = (w_px + STP > XMAX) ? XMAX : w_px + STP;
    end

    always_comb begin
        w_ny = w_py;
        if (i_up && !i_down)
            w_ny = (w_py < STP) ? 11'd0 : w_py - STP;
        else if (i_down && !i_up)
            w_ny = (w_py + STP > YMAX) ? YMAX : w_py + STP;
    end

    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            r_pos_x    <= 10'(START_X);
            r_pos_y    <= 10'(START_Y);
            r_cnt      <= '0;
            r_rom_addr <= '0;
            r_hit_d    <= 1'b0;
            r_pixel    <= 8'h00;
            r_opaque   <= 1'b0;
        end else begin
            if (i_pix_stb) begin
                r_hit_d  <= w_hit;
                r_pixel  <= r_hit_d ? i_rom_data : 8'h00;
                r_opaque <= r_hit_d && (i_rom_data != TRANSP);
                if (w_hit) begin
                    r_rom_addr <= r_cnt;
                    r_cnt      <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                end
            end
            // Frame pulse resyncs the counter and overrides a coincident increment
            if (i_frame_stb) begin
                r_cnt   <= '0;
                r_pos_x <= w_nx[9:0];
                r_pos_y <= w_ny[9:0];
            end
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_pixel    = r_pixel;
    assign o_opaque   = r_opaque;
    assign o_pos_x    = r_pos_x;
    assign o_pos_y    = r_pos_y;
endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render: reset, movement clamps, conflicts,
// full-window address scan, pixel latency/transparency, counter resync.
module tb_sprite_render;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_stb = 1'b0, i_frame_stb = 1'b0, i_active = 1'b0;
    logic [9:0]  i_x = '0, i_y = '0;
    logic        i_left = 1'b0, i_right = 1'b0, i_up = 1'b0, i_down = 1'b0;
    logic [10:0] o_rom_addr;
    logic [7:0]  rom_q = 8'h00;
    logic [7:0]  o_pixel;
    logic        o_opaque;
    logic [9:0]  o_pos_x, o_pos_y;

    int total = 0, bad = 0;
    int mx = 303, my = 222, m_cnt = 0, m_addr = 0;
    bit m_hd = 0;
    logic [7:0] e_pix;
    bit e_opq;

    always #5 clk = ~clk;

    sprite_render dut (
        .i_clk2(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_frame_stb(i_frame_stb),
        .i_active(i_active), .i_x(i_x), .i_y(i_y),
        .i_left(i_left), .i_right(i_right), .i_up(i_up), .i_down(i_down),
        .o_rom_addr(o_rom_addr), .i_rom_data(rom_q), .o_pixel(o_pixel),
        .o_opaque(o_opaque), .o_pos_x(o_pos_x), .o_pos_y(o_pos_y)
    );

    function automatic logic [7:0] rom_f(input int a);
        logic [31:0] v;
        v = a;
        return (a == 1) ? 8'hE3 : v[7:0];
    endfunction

    always @(posedge clk) rom_q <= rom_f(int'(o_rom_addr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic frame(input bit l, r, u, d);
        @(negedge clk);
        i_left = l; i_right = r; i_up = u; i_down = d; i_frame_stb = 1'b1;
        @(negedge clk);
        i_left = 0; i_right = 0; i_up = 0; i_down = 0; i_frame_stb = 1'b0;
        m_cnt = 0;
        if (l && !r) mx = (mx < 2) ? 0 : mx - 2;
        else if (r && !l) mx = (mx + 2 > 606) ? 606 : mx + 2;
        if (u && !d) my = (my < 2) ? 0 : my - 2;
        else if (d && !u) my = (my + 2 > 444) ? 444 : my + 2;
    endtask

    task automatic frames(input int n, input bit l, r, u, d);
        for (int k = 0; k < n; k++) frame(l, r, u, d);
    endtask

    task automatic pix(input int x, y, input bit act, fr);
        bit h;
        logic [7:0] rd;
        h = act && x >= mx && x <= mx + 33 && y >= my && y <= my + 35;
        @(negedge clk);
        i_x = 10'(x); i_y = 10'(y); i_active = act; i_pix_stb = 1'b1; i_frame_stb = fr;
        rd = rom_f(m_addr);
        e_pix = m_hd ? rd : 8'h00;
        e_opq = m_hd && (rd != 8'h00);
        m_hd = h;
        if (h) begin
            m_addr = m_cnt;
            m_cnt = (m_cnt == 1223) ? 0 : m_cnt + 1;
        end
        if (fr) m_cnt = 0;
        @(negedge clk);
        i_pix_stb = 1'b0; i_frame_stb = 1'b0; i_active = 1'b0;
        chk("addr", 32'(o_rom_addr), 32'(m_addr));
        chk("pixel", 32'(o_pixel), 32'(e_pix));
        chk("opaque", 32'(o_opaque), 32'(e_opq));
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic rst_chk();
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        chk("rst_x", 32'(o_pos_x), 303);
        chk("rst_y", 32'(o_pos_y), 222);
        chk("rst_addr", 32'(o_rom_addr), 0);
        chk("rst_pix", 32'(o_pixel), 0);
        chk("rst_opq", 32'(o_opaque), 0);
        @(negedge clk);
        i_rst = 1'b0;
        mx = 303; my = 222; m_cnt = 0; m_addr = 0; m_hd = 0;
    endtask

    task automatic scan(input int px, py);
        frame(0, 0, 0, 0);
        for (int y = py - 1; y <= py + 36; y++)
            for (int x = px - 2; x <= px + 35; x++) begin
                pix(x, y, 1, 0);
                if (y == py && x == px)      chk("a_first", 32'(o_rom_addr), 0);
                if (y == py && x == px + 1)  chk("lat_transp", 32'(o_opaque), 0);
                if (y == py && x == px + 2) begin
                    chk("lat_pix", 32'(o_pixel), 32'h E3);
                    chk("lat_opq", 32'(o_opaque), 1);
                end
                if (y == py && x == px + 33) chk("a_row_end", 32'(o_rom_addr), 33);
                if (y == py && x == px + 35) chk("lat_off", 32'(o_opaque), 0);
                if (y == py + 1 && x == px)  chk("a_row1", 32'(o_rom_addr), 34);
                if (y == py + 35 && x == px + 33) chk("a_last", 32'(o_rom_addr), 1223);
            end
        pix(px, py, 1, 0);
        chk("a_wrap", 32'(o_rom_addr), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("init_x", 32'(o_pos_x), 303);
        chk("init_y", 32'(o_pos_y), 222);
        chk("init_addr", 32'(o_rom_addr), 0);
        chk("init_opq", 32'(o_opaque), 0);

        // right/down clamps
        frames(151, 0, 1, 0, 0); chk("x605", 32'(o_pos_x), 605);
        frame(0, 1, 0, 0);       chk("x606", 32'(o_pos_x), 606);
        frame(0, 1, 0, 0);       chk("x606_hold", 32'(o_pos_x), 606);
        frames(111, 0, 0, 0, 1); chk("y444", 32'(o_pos_y), 444);
        frame(0, 0, 0, 1);       chk("y444_hold", 32'(o_pos_y), 444);

        // async reset mid-sim, then left/up clamps
        rst_chk();
        frames(151, 1, 0, 0, 0); chk("x1", 32'(o_pos_x), 1);
        frame(1, 0, 0, 0);       chk("x1_to0", 32'(o_pos_x), 0);
        frame(1, 0, 0, 0);       chk("x0_hold", 32'(o_pos_x), 0);
        frames(111, 0, 0, 1, 0); chk("y0", 32'(o_pos_y), 0);
        frame(0, 0, 1, 0);       chk("y0_hold", 32'(o_pos_y), 0);

        // conflicting buttons
        frames(100, 0, 1, 0, 1); chk("x200", 32'(o_pos_x), 200); chk("y200", 32'(o_pos_y), 200);
        frame(1, 1, 0, 1);       chk("lr_x", 32'(o_pos_x), 200); chk("lr_y", 32'(o_pos_y), 202);
        frame(0, 1, 1, 1);       chk("ud_x", 32'(o_pos_x), 202); chk("ud_y", 32'(o_pos_y), 202);

        // move to (100,50) and scan the window
        frames(101, 1, 0, 0, 0);
        frames(50, 0, 1, 0, 0);
        frames(76, 0, 0, 1, 0);
        chk("pos100", 32'(o_pos_x), 100); chk("pos50", 32'(o_pos_y), 50);
        scan(100, 50);

        // frame pulse coincident with a hit at cnt=5; inactive pixel never hits
        frame(0, 0, 0, 0);
        for (int x = 100; x < 105; x++) pix(x, 50, 1, 0);
        pix(102, 50, 0, 0);
        chk("inactive_addr", 32'(o_rom_addr), 4);
        pix(105, 50, 1, 1);
        chk("coinc_addr", 32'(o_rom_addr), 5);
        pix(106, 50, 1, 0);
        chk("coinc_cnt0", 32'(o_rom_addr), 0);

        // reset mid-frame at cnt=400, then a clean frame at the reset position
        frame(0, 0, 0, 0);
        for (int y = 50; y < 86 && m_cnt != 400; y++)
            for (int x = 100; x < 134 && m_cnt != 400; x++) pix(x, y, 1, 0);
        chk("pre_rst_addr", 32'(o_rom_addr), 399);
        rst_chk();
        scan(303, 222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_render.md
Name: sprite_render

Overview:
- Pixel-pipeline stage directly upstream of the sprite ROM.
- Holds the sprite position and moves it once per frame from button inputs, clamped to the screen.
- Generates the ROM read address from the VGA raster position, then consumes the ROM pixel one pixel later.
- Outputs the sprite colour plus an opaque flag to the VGA colour mux; runs on the 100 MHz clock, gated by the 25 MHz pixel strobe.

Parameters:
- SPR_W, 34, sprite width in pixels
- SPR_H, 36, sprite height in pixels (SPR_W*SPR_H = 1224 ROM words)
- ADDR_W, 11, ROM address width (covers 0..1223)
- START_X, 303, X position after reset (top-left corner)
- START_Y, 222, Y position after reset
- STEP, 2, pixels moved per frame per pressed direction
- TRANSP, 8'h00, colour value treated as transparent

Ports:
- i_clk2  in  1  system clock, 100 MHz
- i_rst  in  1  asynchronous active-high reset
- i_pix_stb  in  1  pixel strobe, 1 cycle high every 4 clocks
- i_frame_stb  in  1  one-cycle pulse at start of vertical blank
- i_active  in  1  raster is in the visible 640x480 area
- i_x  in  10  current raster column
- i_y  in  10  current raster row
- i_left, i_right, i_up, i_down  in  1 each  movement requests (already synchronised)
- o_rom_addr  out  ADDR_W  read address to sprite ROM
- i_rom_data  in  8  ROM pixel (RRRGGGBB), valid one ROM clock after o_rom_addr
- o_pixel  out  8  sprite colour for the previous strobed pixel
- o_opaque  out  1  high when o_pixel is to be drawn
- o_pos_x  out  10  current sprite X
- o_pos_y  out  10  current sprite Y

Behaviour:
- Reset (async, i_rst=1): pos=(START_X,START_Y), addr counter=0, o_rom_addr=0, o_pixel=0, o_opaque=0, internal hit pipe=0.
- Hit test, combinational on the inputs: hit = i_active & (pos_x <= i_x <= pos_x+SPR_W-1) & (pos_y <= i_y <= pos_y+SPR_H-1). Compare at 11 bits so the sum cannot overflow.
- Address counter, no multiplier:
  - On an i_pix_stb cycle with hit: o_rom_addr <= cnt; cnt <= cnt+1.
  - When cnt reaches SPR_W*SPR_H-1, the increment wraps cnt to 0.
  - Raster order guarantees the counter equals row*SPR_W+col.
- Counter resync: i_frame_stb forces cnt <= 0. If i_frame_stb and an i_pix_stb hit occur in the same cycle, i_frame_stb wins (cnt=0) and o_rom_addr still takes the old cnt.
- Pixel pipeline, one-pixel latency:
  - On each i_pix_stb, hit_d <= hit.
  - On the same strobe, o_pixel <= hit_d ? i_rom_data : 8'h00 and o_opaque <= hit_d & (i_rom_data != TRANSP).
  - So the outputs for the pixel presented at strobe n update at strobe n+1. The ROM data is stable because at least 2 clock edges separate strobes.
  - o_pixel and o_opaque hold between strobes.
- Movement, on i_frame_stb only:
  - left-only: x = max(0, x-STEP). right-only: x = min(640-SPR_W, x+STEP).
  - up-only: y = max(0, y-STEP). down-only: y = min(480-SPR_H, y+STEP).
  - left and right both pressed: no X change. up and down both pressed: no Y change.
  - X and Y update independently in the same cycle.
  - Subtraction is checked before wrap: x < STEP clamps to 0.
  - Position is constant during active video, so the hit window never changes mid-frame.
- Reset mid-frame: all state returns to reset values immediately. o_opaque=0 until the first strobe after release. The address counter is wrong only for the remainder of that frame and is correct from the next i_frame_stb.
- Strobe validity: no state changes on cycles without i_pix_stb or i_frame_stb.

Test Plan:
- Reset with i_rst pulsed mid-sim -> o_pos=(303,222), o_rom_addr=0, o_pixel=0, o_opaque=0 asynchronously, before the next clock edge.
- Full frame with pos forced to (100,50) and behavioural ROM returning addr[7:0] -> o_rom_addr=0 at (100,50), 33 at (133,50), 34 at (100,51), 1223 at (133,85); counter back to 0 after the last hit; no address change outside the window.
- Latency/transparency: ROM word 0=8'h00, word 1=8'hE3 -> strobe after (100,50): o_opaque=0; strobe after (101,50): o_pixel=8'hE3, o_opaque=1; strobe after (134,50): o_opaque=0.
- Clamping: x=605 with i_right plus a frame pulse -> 606, next pulse stays 606; y=1 with i_up -> 0; x=0 with i_left -> stays 0.
- Conflicts: i_left&i_right with i_down at (200,200) -> (200,202). i_frame_stb coincident with a strobe hit at cnt=5 -> o_rom_addr=5, cnt=0.
- Reset mid-frame at cnt=400 -> cnt=0 immediately; after the next i_frame_stb, addresses again run 0..1223 correctly.
